// File: rtl/prime_pkg.sv
// Shared constants, state encoding and the prime predicate for the prime scanner.
// Latency: n/a (elaboration-time constants and functions only).
// Backpressure: n/a.
package prime_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int MAX_WIDTH = 8;

    // Expected detector response for WIDTH=4, bit n set when n is prime.
    localparam logic [15:0] PRIME_MASK_W4 = 16'h28AC;

    typedef enum logic {
        IDLE = 1'b0,
        SCAN = 1'b1
    } scan_state_t;

    // Trial division; any composite below 256 has a factor no larger than 15,
    // so a fixed loop bound keeps this usable as a constant function.
    function automatic logic is_prime(input int n);
        logic p;
        p = (n >= 2);
        for (int d = 2; d < 16; d++) begin
            if ((d < n) && ((n % d) == 0)) begin
                p = 1'b0;
            end
        end
        return p;
    endfunction

    // Full 8-bit prime table; callers slice off the low 2^WIDTH entries.
    function automatic logic [255:0] prime_mask();
        logic [255:0] m;
        m = '0;
        for (int n = 0; n < 256; n++) begin
            m[n] = is_prime(n);
        end
        return m;
    endfunction

endpackage

// File: rtl/prime_ref_lut.sv
// Expected prime flag for a WIDTH-bit code, table built at elaboration.
// Latency: combinational.
// Backpressure: none.
module prime_ref_lut
    import prime_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] code,
    output logic             prime
);

    localparam logic [255:0]          FULL_MASK = prime_mask();
    localparam logic [2**WIDTH-1:0]   MASK      = FULL_MASK[2**WIDTH-1:0];

    assign prime = MASK[code];

endmodule

// File: rtl/prime_scanner.sv
// Exhaustive on-chip sweep of the prime detector with first-mismatch capture.
// Latency: 2^WIDTH*DWELL cycles from accepted start to done.
// Backpressure: start is ignored while busy; results hold until the next accept.
module prime_scanner
    import prime_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             dut_salida,
    output logic [WIDTH-1:0] dut_inputs,
    output logic             busy,
    output logic             done,
    output logic [WIDTH:0]   prime_count,
    output logic             error,
    output logic [WIDTH-1:0] err_value
);

    // A one-bit counter is kept even for DWELL=1; it then simply stays at 0.
    localparam int               CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]    CNT_LAST  = CW'(DWELL - 1);
    localparam logic [WIDTH-1:0] CODE_LAST = '1;

    scan_state_t      state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [WIDTH-1:0] code_nxt;
    logic             done_nxt;
    logic [WIDTH:0]   count_nxt;
    logic             error_nxt;
    logic [WIDTH-1:0] err_value_nxt;
    logic             expected;
    logic             mismatch;

    prime_ref_lut #(
        .WIDTH (WIDTH)
    ) u_ref (
        .code  (dut_inputs),
        .prime (expected)
    );

    assign mismatch = (dut_salida != expected);
    assign busy     = (state == SCAN);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus next values of the sweep counters and result registers.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        code_nxt      = dut_inputs;
        done_nxt      = done;
        count_nxt     = prime_count;
        error_nxt     = error;
        err_value_nxt = err_value;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt     = SCAN;
                    cnt_nxt       = '0;
                    code_nxt      = '0;
                    done_nxt      = 1'b0;
                    count_nxt     = '0;
                    error_nxt     = 1'b0;
                    err_value_nxt = '0;
                end
            end
            SCAN: begin
                if (cnt == CNT_LAST) begin
                    // Sample edge: the detector has had the whole dwell to settle.
                    if (dut_salida) begin
                        count_nxt = prime_count + 1'b1;
                    end
                    // Only the first mismatch of a sweep is recorded.
                    if (mismatch && !error) begin
                        error_nxt     = 1'b1;
                        err_value_nxt = dut_inputs;
                    end
                    cnt_nxt = '0;
                    if (dut_inputs == CODE_LAST) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        code_nxt  = '0;
                    end else begin
                        code_nxt = dut_inputs + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: drive code, dwell counter and sweep results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            dut_inputs  <= '0;
            done        <= 1'b0;
            prime_count <= '0;
            error       <= 1'b0;
            err_value   <= '0;
        end else begin
            cnt         <= cnt_nxt;
            dut_inputs  <= code_nxt;
            done        <= done_nxt;
            prime_count <= count_nxt;
            error       <= error_nxt;
            err_value   <= err_value_nxt;
        end
    end

endmodule

// File: tb/tb_prime_scanner.sv
// Bench for prime_scanner: two instances (DWELL=1 and DWELL=3) against a mask-driven detector model.
// Latency: n/a.
// Backpressure: n/a.
module tb_prime_scanner;

    localparam int W = 4;
    localparam int N = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   start;
    logic [1:0]   sal;
    logic [W-1:0] din [2];
    logic [1:0]   busy;
    logic [1:0]   done;
    logic [1:0]   err;
    logic [W:0]   pc [2];
    logic [W-1:0] ev [2];

    // Detector model: response for code n is bit n of cur_mask.
    logic [N-1:0] cur_mask;
    logic [N-1:0] true_mask;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign sal[0] = cur_mask[din[0]];
    assign sal[1] = cur_mask[din[1]];

    prime_scanner #(.WIDTH(W), .DWELL(1)) u_dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start[0]),
        .dut_salida  (sal[0]),
        .dut_inputs  (din[0]),
        .busy        (busy[0]),
        .done        (done[0]),
        .prime_count (pc[0]),
        .error       (err[0]),
        .err_value   (ev[0])
    );

    prime_scanner #(.WIDTH(W), .DWELL(3)) u_dut3 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start[1]),
        .dut_salida  (sal[1]),
        .dut_inputs  (din[1]),
        .busy        (busy[1]),
        .done        (done[1]),
        .prime_count (pc[1]),
        .error       (err[1]),
        .err_value   (ev[1])
    );

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] ref_primes();
        logic [N-1:0] m;
        m = '0;
        for (int n = 2; n < N; n++) begin
            m[n] = 1'b1;
            for (int d = 2; d < n; d++) begin
                if (n % d == 0) m[n] = 1'b0;
            end
        end
        return m;
    endfunction

    function automatic int popcnt(input logic [N-1:0] m);
        int c;
        c = 0;
        for (int i = 0; i < N; i++) c += int'(m[i]);
        return c;
    endfunction

    function automatic int first_diff(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int i = 0; i < N; i++) begin
            if (a[i] != b[i]) return i;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input int idx, input string tag);
        chk({tag, ".code"},  int'(din[idx]),  0);
        chk({tag, ".busy"},  int'(busy[idx]), 0);
        chk({tag, ".done"},  int'(done[idx]), 0);
        chk({tag, ".count"}, int'(pc[idx]),   0);
        chk({tag, ".error"}, int'(err[idx]),  0);
        chk({tag, ".errv"},  int'(ev[idx]),   0);
    endtask

    // One full sweep on instance idx, entered and left 1 time unit after an edge.
    // pulse_at: sweep cycle at which a one-cycle start pulse is injected (ignored by DUT).
    task automatic sweep(input int idx, input logic [N-1:0] mask, input int pulse_at,
                         input string tag);
        int dw;
        int fd;
        dw = (idx == 0) ? 1 : 3;
        cur_mask   = mask;
        start[idx] = 1'b1;
        @(posedge clk); #1;
        start[idx] = 1'b0;
        chk({tag, ".acc_busy"},  int'(busy[idx]), 1);
        chk({tag, ".acc_done"},  int'(done[idx]), 0);
        chk({tag, ".acc_count"}, int'(pc[idx]),   0);
        chk({tag, ".acc_error"}, int'(err[idx]),  0);
        chk({tag, ".acc_errv"},  int'(ev[idx]),   0);
        for (int c = 0; c < N * dw; c++) begin
            chk({tag, ".code"}, int'(din[idx]),  c / dw);
            chk({tag, ".busy"}, int'(busy[idx]), 1);
            start[idx] = (c == pulse_at);
            @(posedge clk); #1;
        end
        start[idx] = 1'b0;
        fd = first_diff(mask, true_mask);
        chk({tag, ".end_busy"},  int'(busy[idx]), 0);
        chk({tag, ".end_done"},  int'(done[idx]), 1);
        chk({tag, ".end_code"},  int'(din[idx]),  0);
        chk({tag, ".end_count"}, int'(pc[idx]),   popcnt(mask));
        chk({tag, ".end_error"}, int'(err[idx]),  (fd >= 0) ? 1 : 0);
        chk({tag, ".end_errv"},  int'(ev[idx]),   (fd >= 0) ? fd : 0);
    endtask

    initial begin
        logic [N-1:0] m;
        int           idx;
        int           i;
        rst_n     = 1'b0;
        start     = '0;
        cur_mask  = '0;
        true_mask = ref_primes();

        #12;
        check_all_zero(0, "rst1");
        check_all_zero(1, "rst3");
        rst_n = 1'b1;
        @(posedge clk); #1;

        sweep(0, true_mask, -1, "ok_dw1");
        sweep(0, '0, -1, "stuck0");
        sweep(0, true_mask, -1, "b2b_ok");
        sweep(0, true_mask | 16'h0200, -1, "nine");
        sweep(1, true_mask, 10, "ok_dw3");

        // Start held high: done shows for exactly one cycle, then a new sweep begins.
        cur_mask = true_mask;
        start[0] = 1'b1;
        i = 0;
        while (i < 100 && !done[0]) begin
            @(posedge clk); #1;
            i++;
        end
        chk("hold.done_seen", int'(done[0]), 1);
        chk("hold.idle_busy", int'(busy[0]), 0);
        @(posedge clk); #1;
        chk("hold.done_one_cycle", int'(done[0]), 0);
        chk("hold.restart_busy",   int'(busy[0]), 1);
        chk("hold.restart_count",  int'(pc[0]),   0);
        start[0] = 1'b0;
        i = 0;
        while (i < 100 && busy[0]) begin
            @(posedge clk); #1;
            i++;
        end
        chk("hold.second_busy",  int'(busy[0]), 0);
        chk("hold.second_count", int'(pc[0]),   6);

        // Asynchronous reset in the middle of a sweep.
        start[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0;
        i = 0;
        while (i < 50 && din[0] != 4'd7) begin
            @(posedge clk); #1;
            i++;
        end
        chk("midrst.reach7", int'(din[0]), 7);
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero(0, "midrst");
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        sweep(0, true_mask, -1, "post_rst");

        // Randomized detector faults on either instance.
        for (int r = 0; r < 8; r++) begin
            idx = int'($urandom_range(0, 1));
            m   = ($urandom_range(0, 3) == 0) ? true_mask : N'($urandom);
            sweep(idx, m, int'($urandom_range(0, 3 * N - 1)), $sformatf("rnd%0d", r));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/prime_scanner.md
# prime_scanner

Self-checking sequential scanner for the prime-number detector. It sweeps every input code 0 … 2^WIDTH−1 into the detector, holding each code for a programmable dwell. It samples the detector's 1-bit response, compares it against an internally generated expected value, counts reported primes, and latches the first mismatch. It replaces the open-loop stimulus sequence with an on-chip, restartable exhaustive check that also runs on the board.

## Interface
- WIDTH, 4 — detector input width; legal range 2..8.
- DWELL, 1 — clock cycles each code is held on dut_inputs; legal range ≥1.
- clk  in  1  system clock, rising-edge active.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a full sweep; sampled only in IDLE.
- dut_salida  in  1  detector output (1 = prime); combinational from dut_inputs.
- dut_inputs  out  WIDTH  code currently driven to the detector.
- busy  out  1  high while a sweep is in progress.
- done  out  1  sticky; sweep completed; cleared by next accepted start.
- prime_count  out  WIDTH+1  number of codes for which dut_salida was sampled 1.
- error  out  1  sticky; at least one mismatch seen in the current/last sweep.
- err_value  out  WIDTH  code of the first mismatch; 0 when error=0.

## Operation
- Reset (asynchronous, rst_n=0): state IDLE; dut_inputs=0, busy=0, done=0, prime_count=0, error=0, err_value=0, dwell counter=0.
- FSM states: IDLE, SCAN.
- IDLE: start=1 at a rising edge → SCAN. The same edge forces dut_inputs=0, dwell counter=0, prime_count=0, error=0, err_value=0, done=0, busy=1.
- SCAN:
  - Dwell counter increments each cycle, 0..DWELL−1.
  - On the edge where counter=DWELL−1 (sample edge), dut_salida is sampled.
  - If sampled 1: prime_count+1.
  - If sampled ≠ is_prime(dut_inputs) and error=0: error←1 and err_value←dut_inputs. Later mismatches do not overwrite err_value.
  - Sample edge with dut_inputs < 2^WIDTH−1: dut_inputs+1, counter←0.
  - Sample edge with dut_inputs = 2^WIDTH−1: → IDLE; busy←0, done←1, dut_inputs←0. No wrap-around rescan.
- start while busy=1: ignored, no effect on the sweep.
- start held high continuously: a new sweep begins on the first edge in IDLE after completion. done is then high for exactly one cycle.
- Expected value: is_prime(n)=1 for n ∈ {2,3,5,7,11,13,…}. 0 and 1 are not prime. For WIDTH=4 the expected mask (bit n) is 16'h28AC, giving 6 primes.
- prime_count saturates never; WIDTH+1 bits holds the maximum 2^WIDTH.
- Reset mid-sweep: immediate return to reset values; no partial results retained.

## Timing
- Accept: start sampled at edge T0; dut_inputs=0 and busy=1 visible after T0.
- Code k is driven during cycles T0+k·DWELL+1 … T0+(k+1)·DWELL.
- Sample at the last edge of each code's window.
- busy high for exactly 2^WIDTH·DWELL cycles (WIDTH=4, DWELL=1: 16 cycles).
- done, prime_count, error and err_value are final and stable from the edge that clears busy. They hold until the next accepted start or reset.
- dut_salida must settle within one clock period of a dut_inputs change. The DWELL=1 sample occurs at the end of that period.

## Structure
- Package prime_pkg holds:
  - default WIDTH,
  - the constant function is_prime(n),
  - the FSM state encoding (IDLE=0, SCAN=1),
  - the WIDTH=4 expected mask constant 16'h28AC for benches.
- One sub-module, prime_ref_lut: combinational, WIDTH→1, expected prime flag built from is_prime at elaboration. It is instantiated once.
- Counter, FSM and result registers live in prime_scanner.

## Test plan
- Correct detector, WIDTH=4, DWELL=1, start pulse at T0 → busy 16 cycles; dut_inputs steps 0..15; then done=1, prime_count=6, error=0, err_value=0.
- Detector model stuck-at-0 → prime_count=0, error=1, err_value=2, done=1 after 16 cycles.
- Faulty model reporting 9 as prime (otherwise correct) → prime_count=7, error=1, err_value=9.
- DWELL=3 → each code held 3 cycles, busy 48 cycles, same results as the first scenario. Pulse start at cycle 10 of the sweep → ignored, no change to results.
- Assert rst_n=0 at dut_inputs=7 mid-sweep → all outputs 0 immediately; new start gives a full clean sweep with prime_count=6.
- Back-to-back: first sweep with stuck-at-0 model (error=1), then switch to correct model and start → error cleared at accept, final error=0, prime_count=6.
